multi_debouncer: RTL
====================

MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 Parameter N_CH, default 4: number of independent push-button channels (1..16).
REQ-002 Parameter CNT_W, default 17: debounce counter width; the filter interval is 2^CNT_W cycles.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 means raw input low = pressed; 0 means raw input high = pressed.
REQ-004 Parameter HOLD_CYC, default 50000000: pressed cycles before the first auto-repeat pulse (>= 2).
REQ-005 Parameter RPT_CYC, default 10000000: cycles between subsequent auto-repeat pulses (1..HOLD_CYC).
REQ-006 Parameter REPEAT_EN, default 1: 0 forces pb_repeat to zero.
REQ-007 clk  input  1: single clock; all state updates on its rising edge.
REQ-008 rst_n  input  1: synchronous, active-low reset, sampled on the clk rising edge.
REQ-009 pb  input  N_CH: raw, glitchy buttons, asynchronous to clk.
REQ-010 pb_state  output  N_CH: debounced level per channel, 1 = pressed.
REQ-011 pb_down  output  N_CH: one-cycle pulse per channel on a debounced press.
REQ-012 pb_up  output  N_CH: one-cycle pulse per channel on a debounced release.
REQ-013 pb_repeat  output  N_CH: one-cycle auto-repeat pulse per channel while held.
REQ-014 pb_long  output  N_CH: level, 1 while a channel has been held for at least HOLD_CYC cycles.
REQ-015 pb_any  output  1: OR of all pb_state bits.

Function
REQ-016 Each channel SHALL normalise polarity (pressed = 1), then pass the result through a two-flop synchroniser (s0, s1).
REQ-017 A channel is idle when s1 equals pb_state; when idle, its CNT_W-bit counter SHALL clear to 0.
REQ-018 When not idle, the counter SHALL increment by one per cycle; on the cycle the counter is all ones, pb_state SHALL toggle and the counter SHALL wrap to 0.
REQ-019 Any cycle in which s1 returns to pb_state (a bounce) SHALL clear the counter, restarting the filter.
REQ-020 Latency: a clean, stable input change SHALL appear on pb_state at the (2^CNT_W + 2)th rising edge after the change.
REQ-021 pb_down and pb_up SHALL be registered and SHALL be high exactly in the first cycle pb_state reads its new value 1 or 0 respectively; they are never high together on one channel.
REQ-022 Each channel SHALL have a hold counter of ceil(log2(HOLD_CYC)) bits; it is 0 while pb_state = 0, and it is 0 in the pb_down cycle.
REQ-023 The hold counter SHALL increment each cycle while pb_state = 1; when it equals HOLD_CYC-1, it SHALL reload to HOLD_CYC-RPT_CYC.
REQ-024 With REPEAT_EN = 1, pb_repeat SHALL pulse in every cycle the hold counter equals HOLD_CYC-1, i.e. cycles HOLD_CYC-1, HOLD_CYC-1+RPT_CYC, and so on, counted from the pb_down cycle (cycle 0).
REQ-025 pb_long SHALL rise in the cycle of the first threshold hit (regardless of REPEAT_EN) and SHALL fall in the pb_up cycle.
REQ-026 On release, the hold counter SHALL clear in the pb_up cycle; a repeat due in that same cycle SHALL be suppressed.
REQ-027 Channels SHALL be fully independent; simultaneous events on different channels SHALL produce simultaneous pulses.
REQ-028 pb_any SHALL be combinational from pb_state.

Reset
REQ-029 When rst_n = 0 at a rising edge: s0, s1, both counters, pb_state, pb_down, pb_up, pb_repeat and pb_long SHALL all become 0 for every channel.
REQ-030 Reset mid-filter or mid-hold SHALL discard all progress; no pulse SHALL be emitted in the cycle after reset.
REQ-031 A button held through reset deassertion SHALL be reported as a new press 2^CNT_W + 2 cycles after rst_n rises.

Verification (N_CH=2, CNT_W=3, ACTIVE_LOW=1, HOLD_CYC=20, RPT_CYC=6, REPEAT_EN=1)
REQ-032 pb[0] driven 1->0 and held -> pb_state[0] = 1 and one-cycle pb_down[0] at edge 10; pb[1] outputs stay 0.
REQ-033 pb[0] low for 5 cycles then high 1 cycle, repeated -> pb_state[0] never rises, no pulses.
REQ-034 pb[0] held low -> pb_repeat[0] at cycles 19, 25, 31 after pb_down; pb_long[0] rises at 19; release -> pb_up[0] once, pb_long[0] = 0 in the same cycle.
REQ-035 Both pb bits fall in the same cycle -> pb_down = 2'b11 in one cycle; pb_any = 1.
REQ-036 rst_n pulsed low at cycle 7 of filtering -> all outputs 0; with pb held low, the press is reported 10 edges after rst_n returns high.
REQ-037 Rebuild with REPEAT_EN=0 and hold for 40 cycles -> pb_repeat stays 0, pb_long[0] rises at cycle 19.

Source files
------------

// File: rtl/multi_debouncer.sv
// Multi-channel push-button debouncer with press/release pulses, auto-repeat and long-press level.
// Each channel: polarity normalise, 2-flop sync, saturating-interval filter, hold/repeat timer.
module multi_debouncer #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned CNT_W      = 17,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned HOLD_CYC   = 50000000,
  parameter int unsigned RPT_CYC    = 10000000,
  parameter bit          REPEAT_EN  = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb,
  output logic [N_CH-1:0] pb_state,
  output logic [N_CH-1:0] pb_down,
  output logic [N_CH-1:0] pb_up,
  output logic [N_CH-1:0] pb_repeat,
  output logic [N_CH-1:0] pb_long,
  output logic            pb_any
);

  localparam int unsigned HoldW = $clog2(HOLD_CYC);
  localparam logic [HoldW-1:0] HoldMax    = HoldW'(HOLD_CYC - 1);
  localparam logic [HoldW-1:0] HoldReload = HoldW'(HOLD_CYC - RPT_CYC);

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    logic             s0_q, s1_q;
    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             down_q, down_d;
    logic             up_q, up_d;
    logic             rpt_q, rpt_d;
    logic             long_q, long_d;
    logic             toggle;

    always_comb begin
      toggle  = 1'b0;
      state_d = state_q;
      cnt_d   = '0;
      if (s1_q != state_q) begin
        if (cnt_q == '1) begin
          toggle  = 1'b1;
          state_d = ~state_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Hold timer runs only while pressed before and after this edge: zero in down/up cycles.
      hold_d = '0;
      if (state_q && state_d) begin
        hold_d = (hold_q == HoldMax) ? HoldReload : hold_q + HoldW'(1);
      end

      // Outputs are registered, so look at the next hold value to align with the threshold cycle.
      rpt_d  = REPEAT_EN && (hold_d == HoldMax);
      long_d = state_d && (long_q || (hold_d == HoldMax));
      down_d = toggle && !state_q;
      up_d   = toggle && state_q;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s0_q    <= 1'b0;
        s1_q    <= 1'b0;
        state_q <= 1'b0;
        cnt_q   <= '0;
        hold_q  <= '0;
        down_q  <= 1'b0;
        up_q    <= 1'b0;
        rpt_q   <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        s0_q    <= pb[i] ^ ACTIVE_LOW;
        s1_q    <= s0_q;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hold_q  <= hold_d;
        down_q  <= down_d;
        up_q    <= up_d;
        rpt_q   <= rpt_d;
        long_q  <= long_d;
      end
    end

    assign pb_state[i]  = state_q;
    assign pb_down[i]   = down_q;
    assign pb_up[i]     = up_q;
    assign pb_repeat[i] = rpt_q;
    assign pb_long[i]   = long_q;
  end

  assign pb_any = |pb_state;

endmodule
